// File: rtl/mem_io_ctrl.sv
// Memory and I/O target for the 16-bit accumulator CPU: word RAM below IO_BASE,
// GPIO and a compare timer with interrupt in the top 16 words. Reads are combinational.
`timescale 1ns/1ps
module mem_io_ctrl #(
  parameter logic [9:0] IO_BASE     = 10'h3F0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  addr,
  input  logic        wr,
  input  logic [15:0] data_wr,
  output logic [15:0] data_rd,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic        irq
);

  localparam logic [9:0] OFF_GPIO_OUT = 10'd0;
  localparam logic [9:0] OFF_GPIO_IN  = 10'd1;
  localparam logic [9:0] OFF_TCTRL    = 10'd2;
  localparam logic [9:0] OFF_TCMP     = 10'd3;
  localparam logic [9:0] OFF_TCNT     = 10'd4;
  localparam logic [9:0] OFF_STATUS   = 10'd5;

  logic [15:0] ram [0:IO_BASE-1];

  logic [2:0]  ctrl;      // bit0 en, bit1 autoreload, bit2 irq_en
  logic [15:0] cmp;
  logic [15:0] cnt;
  logic [1:0]  status;    // bit0 match, bit1 gpio_chg
  logic [15:0] sync_q [SYNC_STAGES];
  logic [15:0] gpio_sync;
  logic [15:0] gpio_prev;

  logic        is_ram;
  logic [9:0]  io_off;
  logic        wr_io;
  logic        match_hit;
  logic        chg_hit;
  logic [15:0] cnt_nxt;
  logic [1:0]  status_nxt;

  assign is_ram    = (addr < IO_BASE);
  assign io_off    = addr - IO_BASE;
  assign wr_io     = wr && !is_ram;
  assign gpio_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    match_hit  = ctrl[0] && (cnt == cmp);
    chg_hit    = (gpio_sync != gpio_prev);
    cnt_nxt    = cnt;
    if (ctrl[0])
      cnt_nxt = (match_hit && ctrl[1]) ? 16'h0000 : cnt + 16'h0001;
    // CPU load wins over counting; the compare above already used the old count
    if (wr_io && io_off == OFF_TCNT)
      cnt_nxt = data_wr;
    status_nxt = status;
    if (wr_io && io_off == OFF_STATUS)
      status_nxt = status & ~data_wr[1:0];
    if (match_hit)
      status_nxt[0] = 1'b1;
    if (chg_hit)
      status_nxt[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out  <= 16'h0000;
      ctrl      <= 3'b000;
      cmp       <= 16'hFFFF;
      cnt       <= 16'h0000;
      status    <= 2'b00;
      irq       <= 1'b0;
      gpio_prev <= 16'h0000;
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= 16'h0000;
    end else begin
      if (wr_io && io_off == OFF_GPIO_OUT)
        gpio_out <= data_wr;
      if (wr_io && io_off == OFF_TCTRL)
        ctrl <= data_wr[2:0];
      if (wr_io && io_off == OFF_TCMP)
        cmp <= data_wr;
      cnt       <= cnt_nxt;
      status    <= status_nxt;
      irq       <= ctrl[2] && status_nxt[0];
      gpio_prev <= gpio_sync;
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  // RAM contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr && is_ram)
      ram[addr] <= data_wr;
  end

  always_comb begin
    data_rd = 16'h0000;
    if (is_ram) begin
      data_rd = ram[addr];
    end else begin
      case (io_off)
        OFF_GPIO_OUT: data_rd = gpio_out;
        OFF_GPIO_IN:  data_rd = gpio_sync;
        OFF_TCTRL:    data_rd = {13'h0000, ctrl};
        OFF_TCMP:     data_rd = cmp;
        OFF_TCNT:     data_rd = cnt;
        OFF_STATUS:   data_rd = {14'h0000, status};
        default:      data_rd = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl: RAM, register map, timer modes, GPIO sync, reset.
`timescale 1ns/1ps
module tb_mem_io_ctrl;

  localparam logic [9:0] A_GPIO_OUT = 10'h3F0;
  localparam logic [9:0] A_GPIO_IN  = 10'h3F1;
  localparam logic [9:0] A_TCTRL    = 10'h3F2;
  localparam logic [9:0] A_TCMP     = 10'h3F3;
  localparam logic [9:0] A_TCNT     = 10'h3F4;
  localparam logic [9:0] A_STATUS   = 10'h3F5;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr;
  logic        wr;
  logic [15:0] data_wr;
  logic [15:0] data_rd;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  mem_io_ctrl #(.IO_BASE(10'h3F0), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .data_wr(data_wr),
    .data_rd(data_rd), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #50 clk = ~clk;

  task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [9:0] a, input logic [15:0] d);
    addr    = a;
    data_wr = d;
    wr      = 1'b1;
    step();
    wr      = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [15:0] exp, input string tag);
    addr = a;
    #1;
    chk(data_rd, exp, tag);
  endtask

  logic [15:0] wrap_exp [6];

  initial begin
    rst = 1'b1; wr = 1'b0; addr = '0; data_wr = '0; gpio_in = '0;
    wrap_exp = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    step();
    step();
    chk(gpio_out, 16'h0000, "rst_gpio_out");
    chk({15'h0, irq}, 16'h0000, "rst_irq");
    rd(A_TCTRL, 16'h0000, "rst_tctrl");
    rd(A_TCMP, 16'hFFFF, "rst_tcmp");
    rd(A_TCNT, 16'h0000, "rst_tcnt");
    rd(A_STATUS, 16'h0000, "rst_status");
    rst = 1'b0;

    // RAM and GPIO_OUT decode
    write(10'h000, 16'hA5A5);
    write(10'h3EF, 16'h1234);
    rd(10'h000, 16'hA5A5, "ram_lo");
    rd(10'h3EF, 16'h1234, "ram_hi");
    write(A_GPIO_OUT, 16'h5A5A);
    chk(gpio_out, 16'h5A5A, "gpio_out_pin");
    rd(A_GPIO_OUT, 16'h5A5A, "gpio_out_rd");
    rd(10'h3EF, 16'h1234, "ram_hi_untouched");
    rd(10'h000, 16'hA5A5, "ram_lo_untouched");

    // Autoreload timer with irq
    write(A_TCNT, 16'h0000);
    write(A_TCMP, 16'h0005);
    write(A_TCTRL, 16'h0007);
    rd(A_TCNT, 16'h0000, "ar_cnt0");
    for (int i = 1; i <= 5; i++) begin
      step();
      rd(A_TCNT, 16'(i), "ar_cnt");
      chk({15'h0, irq}, 16'h0000, "ar_irq_low");
    end
    step();
    rd(A_TCNT, 16'h0000, "ar_reload");
    rd(A_STATUS, 16'h0001, "ar_match");
    chk({15'h0, irq}, 16'h0001, "ar_irq_high");
    write(A_STATUS, 16'h0001);
    rd(A_STATUS, 16'h0000, "w1c_status");
    chk({15'h0, irq}, 16'h0000, "w1c_irq");
    rd(A_TCNT, 16'h0001, "w1c_cnt");
    addr = A_TCNT;
    #1;
    for (int k = 0; k < 20 && data_rd != 16'h0005; k++) step();
    rd(A_TCNT, 16'h0005, "wait_cnt5");
    write(A_STATUS, 16'h0001);
    rd(A_STATUS, 16'h0001, "set_beats_clr");
    chk({15'h0, irq}, 16'h0001, "set_beats_clr_irq");
    rd(A_TCNT, 16'h0000, "set_beats_clr_cnt");

    // Register map corner cases
    write(A_TCTRL, 16'hFFF8);
    rd(A_TCTRL, 16'h0000, "tctrl_upper");
    write(10'h3F6, 16'hBEEF);
    rd(10'h3F6, 16'h0000, "unmapped");
    write(A_GPIO_IN, 16'hFFFF);
    rd(A_GPIO_IN, 16'h0000, "gpio_in_ro");

    // Non-reload wrap
    write(A_TCNT, 16'hFFFE);
    write(A_TCMP, 16'h0003);
    write(A_STATUS, 16'h0003);
    write(A_TCTRL, 16'h0001);
    rd(A_TCNT, 16'hFFFE, "wrap_start");
    for (int i = 0; i < 6; i++) begin
      step();
      rd(A_TCNT, wrap_exp[i], "wrap_cnt");
      rd(A_STATUS, (i == 5) ? 16'h0001 : 16'h0000, "wrap_match");
      chk({15'h0, irq}, 16'h0000, "wrap_irq");
    end

    // TCNT write in the matching cycle
    write(A_TCTRL, 16'h0000);
    write(A_TCNT, 16'h0003);
    write(A_STATUS, 16'h0003);
    write(A_TCTRL, 16'h0001);
    rd(A_STATUS, 16'h0000, "coll_pre");
    write(A_TCNT, 16'h0100);
    rd(A_TCNT, 16'h0100, "coll_cnt");
    rd(A_STATUS, 16'h0001, "coll_match");

    // GPIO synchronizer and change flag
    write(A_TCTRL, 16'h0000);
    write(A_STATUS, 16'h0003);
    gpio_in = 16'h00FF;
    step();
    rd(A_GPIO_IN, 16'h0000, "sync_1edge");
    step();
    rd(A_GPIO_IN, 16'h00FF, "sync_2edge");
    rd(A_STATUS, 16'h0000, "chg_not_yet");
    step();
    rd(A_STATUS, 16'h0002, "chg_set");
    write(A_STATUS, 16'h0002);
    rd(A_STATUS, 16'h0000, "chg_clr");

    // Reset while running with irq asserted
    write(A_TCMP, 16'h0002);
    write(A_TCNT, 16'h0000);
    write(A_TCTRL, 16'h0007);
    for (int k = 0; k < 10 && irq !== 1'b1; k++) step();
    chk({15'h0, irq}, 16'h0001, "pre_rst_irq");
    rst = 1'b1;
    step();
    chk(gpio_out, 16'h0000, "mid_rst_gpio_out");
    chk({15'h0, irq}, 16'h0000, "mid_rst_irq");
    rd(A_TCTRL, 16'h0000, "mid_rst_tctrl");
    rd(A_TCMP, 16'hFFFF, "mid_rst_tcmp");
    rd(A_TCNT, 16'h0000, "mid_rst_tcnt");
    rd(A_STATUS, 16'h0000, "mid_rst_status");
    rd(A_GPIO_IN, 16'h0000, "mid_rst_gpio_in");
    rd(10'h000, 16'hA5A5, "mid_rst_ram_lo");
    rd(10'h3EF, 16'h1234, "mid_rst_ram_hi");
    rst = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
